// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and source-use decode
// for the pipeline hazard controller and the bypass network.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MDU = 2'd1,
    ST_LDW = 2'd2
  } ctl_state_e;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// hazard_mdu_timer: 4-bit loadable down-counter that saturates at zero and
// tracks the remaining MDU occupancy cycles.
module hazard_mdu_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, MDU occupancy, dmem wait and redirect.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        ex_mdu_op,
  input  logic        ex_redirect,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        hold_if,
  output logic        hold_all,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        bubble_memwb,
  output logic        mdu_done,
  output logic [1:0]  ctl_state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam bit         MDU_STALLS = (MDU_LAT > 1);
  localparam logic [3:0] MDU_LOAD   = 4'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

  ctl_state_e state_q, state_d;
  logic       ex_ld_valid_q, ex_ld_valid_d;
  logic [4:0] ex_ld_rd_q, ex_ld_rd_d;

  logic       tmr_load, tmr_dec, tmr_zero;
  logic [3:0] tmr_cnt;
  logic       load_use;
  logic       hold_if_c;

  hazard_mdu_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (MDU_LOAD),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign load_use = ex_ld_valid_q && (ex_ld_rd_q != 5'd0) && id_valid &&
                    ((uses_rs1(id_opcode) && (id_rs1_addr == ex_ld_rd_q)) ||
                     (uses_rs2(id_opcode) && (id_rs2_addr == ex_ld_rd_q)));

  always_comb begin
    state_d      = state_q;
    hold_if_c    = 1'b0;
    hold_all     = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    bubble_memwb = 1'b0;
    mdu_done     = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    if (state_q == ST_MDU) begin
      if (!tmr_zero) begin
        hold_all     = 1'b1;
        bubble_memwb = 1'b1;
        tmr_dec      = 1'b1;
      end else begin
        mdu_done = 1'b1;
        state_d  = ST_RUN;
      end
    end else if ((state_q == ST_LDW) && !dmem_ack) begin
      hold_all     = 1'b1;
      bubble_memwb = 1'b1;
    end else begin
      // A released LDW cycle is decoded exactly like RUN so nothing queued behind it is lost.
      state_d = ST_RUN;
      if (dmem_req && !dmem_ack) begin
        hold_all     = 1'b1;
        bubble_memwb = 1'b1;
        state_d      = ST_LDW;
      end else if (ex_mdu_op && MDU_STALLS) begin
        hold_all = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_MDU;
      end else begin
        mdu_done = ex_mdu_op;
        if (ex_redirect) begin
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (load_use) begin
          hold_if_c   = 1'b1;
          bubble_idex = 1'b1;
        end
      end
    end
  end

  assign hold_if   = hold_if_c | hold_all;
  assign ctl_state = state_q;

  always_comb begin
    ex_ld_valid_d = ex_ld_valid_q;
    ex_ld_rd_d    = ex_ld_rd_q;
    if (!hold_all) begin
      ex_ld_valid_d = id_valid && (id_opcode == OPC_LOAD) && !bubble_idex;
      ex_ld_rd_d    = id_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      ex_ld_valid_q <= 1'b0;
      ex_ld_rd_q    <= 5'd0;
    end else begin
      state_q       <= state_d;
      ex_ld_valid_q <= ex_ld_valid_d;
      ex_ld_rd_q    <= ex_ld_rd_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, hold_if};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_ifid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

  logic unused_tmr;
  assign unused_tmr = ^tmr_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4 main instance,
// MDU_LAT=1 side instance); perf expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ex_mdu_op, ex_redirect, dmem_req, dmem_ack;

  logic        hold_if, hold_all, bubble_idex, flush_ifid, bubble_memwb, mdu_done;
  logic [1:0]  ctl_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  logic        hold_if1, hold_all1, bubble_idex1, flush_ifid1, bubble_memwb1, mdu_done1;
  logic [1:0]  ctl_state1;
  logic [31:0] perf_stall_cnt1, perf_flush_cnt1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] ctl;
  } exp_t;

  exp_t sb[$];

  // expected vector bit order: hold_if hold_all bubble_idex flush_ifid bubble_memwb mdu_done ctl_state[1:0]
  localparam logic [7:0] E_IDLE   = 8'b0000_0000;
  localparam logic [7:0] E_LDUSE  = 8'b1010_0000;
  localparam logic [7:0] E_REDIR  = 8'b0011_0000;
  localparam logic [7:0] E_MDUGO  = 8'b1100_0000;
  localparam logic [7:0] E_MDUHLD = 8'b1100_1001;
  localparam logic [7:0] E_MDUDN  = 8'b0000_0101;
  localparam logic [7:0] E_LDWGO  = 8'b1100_1000;
  localparam logic [7:0] E_LDWHLD = 8'b1100_1010;
  localparam logic [7:0] E_LDWREL = 8'b0000_0010;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd1;
  localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  pipe_hazard_ctrl #(.MDU_LAT(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rd_addr     (id_rd_addr),
    .ex_mdu_op      (ex_mdu_op),
    .ex_redirect    (ex_redirect),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .hold_if        (hold_if),
    .hold_all       (hold_all),
    .bubble_idex    (bubble_idex),
    .flush_ifid     (flush_ifid),
    .bubble_memwb   (bubble_memwb),
    .mdu_done       (mdu_done),
    .ctl_state      (ctl_state),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  pipe_hazard_ctrl #(.MDU_LAT(1)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rd_addr     (id_rd_addr),
    .ex_mdu_op      (ex_mdu_op),
    .ex_redirect    (ex_redirect),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .hold_if        (hold_if1),
    .hold_all       (hold_all1),
    .bubble_idex    (bubble_idex1),
    .flush_ifid     (flush_ifid1),
    .bubble_memwb   (bubble_memwb1),
    .mdu_done       (mdu_done1),
    .ctl_state      (ctl_state1),
    .perf_stall_cnt (perf_stall_cnt1),
    .perf_flush_cnt (perf_flush_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // drive one cycle of inputs and queue the controller response they must produce
  task automatic applyStimulus(input string tag, input logic rstn, input logic idv,
                               input logic [6:0] opc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic mdu, input logic redir,
                               input logic req, input logic ack,
                               input logic [7:0] exp_ctl);
    exp_t e;
    rst_n       = rstn;
    id_valid    = idv;
    id_opcode   = opc;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rd_addr  = rd;
    ex_mdu_op   = mdu;
    ex_redirect = redir;
    dmem_req    = req;
    dmem_ack    = ack;
    e.tag = tag;
    e.ctl = exp_ctl;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    @(negedge clk);
    obs = {hold_if, hold_all, bubble_idex, flush_ifid, bubble_memwb, mdu_done, ctl_state};
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      total++;
      assert (obs === e.ctl) else begin
        bad++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.ctl);
      end
    end
  endtask

  task automatic step(input string tag, input logic rstn, input logic idv,
                      input logic [6:0] opc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mdu, input logic redir,
                      input logic req, input logic ack,
                      input logic [7:0] exp_ctl);
    applyStimulus(tag, rstn, idv, opc, rs1, rs2, rd, mdu, redir, req, ack, exp_ctl);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPerf(input string tag, input logic [31:0] exp_s, input logic [31:0] exp_f);
    total++;
    assert (perf_stall_cnt === exp_s) else begin
      bad++;
      $error("[TB] FAIL %s_stall observed=%0d expected=%0d", tag, perf_stall_cnt, exp_s);
    end
    total++;
    assert (perf_flush_cnt === exp_f) else begin
      bad++;
      $error("[TB] FAIL %s_flush observed=%0d expected=%0d", tag, perf_flush_cnt, exp_f);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {id_valid, ex_mdu_op, ex_redirect, dmem_req, dmem_ack} = '0;
    id_opcode = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    @(posedge clk);
    #1;

    step("reset_idle", 1'b0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE);
    checkPerf("perf_reset", 32'd0, 32'd0);

    // load-use on rs1, then release
    step("lu_load",    1, 1, OPC_LOAD, 5'd2, 5'd0, 5'd5, 0, 0, 0, 0, E_IDLE);
    step("lu_stall",   1, 1, OPC_OP,   5'd5, 5'd1, 5'd6, 0, 0, 0, 0, E_LDUSE);
    step("lu_release", 1, 1, OPC_OP,   5'd5, 5'd1, 5'd6, 0, 0, 0, 0, E_IDLE);
    // load to x0 never stalls
    step("x0_load",    1, 1, OPC_LOAD, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE);
    step("x0_nostall", 1, 1, OPC_OP,   5'd0, 5'd1, 5'd6, 0, 0, 0, 0, E_IDLE);
    // redirect wins over load-use and kills the tracked load
    step("rd_load",    1, 1, OPC_LOAD, 5'd2, 5'd0, 5'd5, 0, 0, 0, 0, E_IDLE);
    step("rd_flush",   1, 1, OPC_OP,   5'd5, 5'd1, 5'd6, 0, 1, 0, 0, E_REDIR);
    step("rd_noload",  1, 1, OPC_OP,   5'd5, 5'd1, 5'd6, 0, 0, 0, 0, E_IDLE);
    checkPerf("perf_lu_rd", EXP_STALL, EXP_FLUSH);

    // rs2 match on a store stalls; LUI ignores its rs1 field
    step("st_load",    1, 1, OPC_LOAD,  5'd2, 5'd0, 5'd7, 0, 0, 0, 0, E_IDLE);
    step("st_rs2",     1, 1, OPC_STORE, 5'd3, 5'd7, 5'd0, 0, 0, 0, 0, E_LDUSE);
    step("lui_load",   1, 1, OPC_LOAD,  5'd2, 5'd0, 5'd8, 0, 0, 0, 0, E_IDLE);
    step("lui_nouse",  1, 1, OPC_LUI,   5'd8, 5'd8, 5'd9, 0, 0, 0, 0, E_IDLE);
    step("op_load",    1, 1, OPC_LOAD,  5'd2, 5'd0, 5'd9, 0, 0, 0, 0, E_IDLE);
    step("jal_nouse",  1, 1, OPC_JAL,   5'd9, 5'd9, 5'd1, 0, 0, 0, 0, E_IDLE);

    // MDU_LAT=4: three held cycles, result on the fourth
    applyStimulus("mdu_start", 1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUGO);
    checkOutput();
    total++;
    assert ({hold_all1, mdu_done1} === 2'b01) else begin
      bad++;
      $error("[TB] FAIL lat1_done observed=%b expected=%b", {hold_all1, mdu_done1}, 2'b01);
    end
    @(posedge clk);
    #1;
    step("mdu_hold1",  1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, E_MDUHLD);
    step("mdu_hold2",  1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUHLD);
    step("mdu_done",   1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUDN);
    step("mdu_run",    1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE);

    // dmem wait: ack arrives on the third cycle
    step("ldw_start",  1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_LDWGO);
    step("ldw_hold",   1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_LDWHLD);
    step("ldw_ack",    1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, E_LDWREL);
    step("ldw_run",    1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE);

    // reset mid-count, then a full MDU sequence again
    step("rst_mdu_go", 1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUGO);
    step("rst_mdu_h1", 1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUHLD);
    step("rst_async",  0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUGO);
    step("rst_held",   0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUGO);
    step("re_start",   1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUGO);
    step("re_hold1",   1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUHLD);
    step("re_hold2",   1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUHLD);
    step("re_done",    1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_MDUDN);
    step("re_run",     1, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
